// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings and helpers for the branch predictor and resolve logic.
// Opcodes are instruction bits [6:2]; func3 values select the branch condition.
package branch_predict_unit_pkg;

   localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
   localparam logic [4:0] OPCODE_JALR   = 5'b11001;
   localparam logic [4:0] OPCODE_JAL    = 5'b11011;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } br_func_e;

   // Two-bit saturating counter step toward the resolved direction.
   function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
      if (taken) begin
         return (cnt == 2'b11) ? cnt : cnt + 2'b01;
      end
      return (cnt == 2'b00) ? cnt : cnt - 2'b01;
   endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump outcome decode from ALU flags, shared by later stages.
// bht_update_o marks a valid conditional branch whose counter must be trained.
module branch_resolve
   import branch_predict_unit_pkg::*;
(
   input  logic       valid_i,
   input  logic [4:0] opcode_i,
   input  logic [2:0] func3_i,
   input  logic       cf_i,
   input  logic       zf_i,
   input  logic       vf_i,
   input  logic       sf_i,
   input  logic       pred_taken_i,
   output logic       br_taken_o,
   output logic       mispredict_o,
   output logic       bht_update_o
);

   always_comb begin
      br_taken_o   = 1'b0;
      bht_update_o = 1'b0;
      if (valid_i) begin
         if (opcode_i == OPCODE_JAL || opcode_i == OPCODE_JALR) begin
            br_taken_o = 1'b1;
         end else if (opcode_i == OPCODE_BRANCH) begin
            bht_update_o = 1'b1;
            // Unlisted func3 resolves not-taken but still trains the counter.
            case (func3_i)
               BR_BEQ:  br_taken_o = zf_i;
               BR_BNE:  br_taken_o = ~zf_i;
               BR_BLT:  br_taken_o = (sf_i != vf_i);
               BR_BGE:  br_taken_o = (sf_i == vf_i);
               BR_BLTU: br_taken_o = ~cf_i;
               BR_BGEU: br_taken_o = cf_i;
               default: br_taken_o = 1'b0;
            endcase
         end
      end
      mispredict_o = valid_i & (br_taken_o ^ pred_taken_i);
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal predictor: flop-based table of 2-bit counters indexed by pc[IDX_W+1:2],
// zero-latency resolve outputs and saturating branch/mispredict statistics.
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter int          IDX_W    = 6,
   parameter logic [1:0]  INIT_CNT = 2'b01,
   parameter int          STAT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   if_pc,
   output logic              pred_taken,
   input  logic              ex_valid,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic [4:0]        opcode,
   input  logic [2:0]        func3,
   input  logic              cf,
   input  logic              zf,
   input  logic              vf,
   input  logic              sf,
   input  logic              ex_pred_taken,
   output logic              br_taken,
   output logic              mispredict,
   output logic [STAT_W-1:0] branch_cnt,
   output logic [STAT_W-1:0] mispredict_cnt
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [1:0]        bht_q [ENTRIES];
   logic [IDX_W-1:0]  if_idx;
   logic [IDX_W-1:0]  ex_idx;
   logic              bht_update;
   logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [STAT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
   logic              unused_pc_bits;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                             ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

   branch_resolve u_resolve (
      .valid_i      (ex_valid),
      .opcode_i     (opcode),
      .func3_i      (func3),
      .cf_i         (cf),
      .zf_i         (zf),
      .vf_i         (vf),
      .sf_i         (sf),
      .pred_taken_i (ex_pred_taken),
      .br_taken_o   (br_taken),
      .mispredict_o (mispredict),
      .bht_update_o (bht_update)
   );

   // Read straight from the table: a same-cycle update is not bypassed.
   assign pred_taken = bht_q[if_idx][1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht_q[i] <= INIT_CNT;
         end
      end else if (bht_update) begin
         bht_q[ex_idx] <= cnt_update(bht_q[ex_idx], br_taken);
      end
   end

   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (ex_valid && branch_cnt_q != '1) begin
         branch_cnt_d = branch_cnt_q + STAT_W'(1);
      end
      if (mispredict && mispredict_cnt_q != '1) begin
         mispredict_cnt_d = mispredict_cnt_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench: resolve expectations go into a scoreboard queue and a negedge
// monitor checks them whenever ex_valid is presented; state checks are inline.
module tb_branch_predict_unit;

   localparam logic [4:0] OP_BR   = 5'b11000;
   localparam logic [4:0] OP_JALR = 5'b11001;
   localparam logic [4:0] OP_JAL  = 5'b11011;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] if_pc = 32'h100;
   logic        pred_taken;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic [4:0]  opcode = '0;
   logic [2:0]  func3 = '0;
   logic        cf = 1'b0, zf = 1'b0, vf = 1'b0, sf = 1'b0;
   logic        ex_pred_taken = 1'b0;
   logic        br_taken, mispredict;
   logic [31:0] branch_cnt, mispredict_cnt;

   typedef struct {
      string name;
      logic  br;
      logic  mp;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   branch_predict_unit dut (
      .clk            (clk),
      .rst            (rst),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .opcode         (opcode),
      .func3          (func3),
      .cf             (cf),
      .zf             (zf),
      .vf             (vf),
      .sf             (sf),
      .ex_pred_taken  (ex_pred_taken),
      .br_taken       (br_taken),
      .mispredict     (mispredict),
      .branch_cnt     (branch_cnt),
      .mispredict_cnt (mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   // Monitor: pops one expectation per presented resolve.
   always @(negedge clk) begin
      if (ex_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resolve actual=ex_valid required=empty_scoreboard");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, "_br_taken"}, 32'(br_taken), 32'(e.br));
            chk({e.name, "_mispredict"}, 32'(mispredict), 32'(e.mp));
         end
      end
   end

   task automatic issue(input string name, input logic [31:0] pc, input logic [4:0] opc,
                        input logic [2:0] f3, input logic c, input logic z, input logic v,
                        input logic s, input logic pred, input logic exp_br, input logic exp_mp);
      exp_t e;
      @(posedge clk);
      #1;
      ex_valid = 1'b1;
      ex_pc = pc;
      opcode = opc;
      func3 = f3;
      cf = c;
      zf = z;
      vf = v;
      sf = s;
      ex_pred_taken = pred;
      e.name = name;
      e.br = exp_br;
      e.mp = exp_mp;
      sb_q.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
   endtask

   initial begin
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #3;
      chk("reset_pred_0x100", 32'(pred_taken), 32'd0);
      chk("reset_branch_cnt", branch_cnt, 32'd0);
      chk("reset_mispredict_cnt", mispredict_cnt, 32'd0);

      // Jumps: always taken, never train the table.
      if_pc = 32'h200;
      issue("jal_0x200", 32'h200, OP_JAL, 3'd0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
      issue("jalr_0x200", 32'h200, OP_JALR, 3'd0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
      idle();
      chk("jal_no_update_pred_0x200", 32'(pred_taken), 32'd0);

      // BEQ taken three times: counter 1->2->3->3.
      if_pc = 32'h100;
      issue("beq1", 32'h100, OP_BR, 3'b000, 0, 1, 0, 0, 1'b0, 1'b1, 1'b1);
      #3 chk("beq1_pred_pre_update", 32'(pred_taken), 32'd0);
      issue("beq2", 32'h100, OP_BR, 3'b000, 0, 1, 0, 0, 1'b0, 1'b1, 1'b1);
      #3 chk("beq2_pred_after_first", 32'(pred_taken), 32'd1);
      issue("beq3", 32'h100, OP_BR, 3'b000, 0, 1, 0, 0, 1'b1, 1'b1, 1'b0);
      idle();
      ex_pred_taken = 1'b1;
      #1;
      chk("idle_br_taken", 32'(br_taken), 32'd0);
      chk("idle_mispredict", 32'(mispredict), 32'd0);
      chk("stat_branch_5", branch_cnt, 32'd5);
      chk("stat_mispredict_3", mispredict_cnt, 32'd3);
      if_pc = 32'h200;
      #1 chk("alias_0x200_idx0_pred", 32'(pred_taken), 32'd1);

      // Condition decode at 0x10: counter 1->2->1->2->3->2->1.
      issue("bltu_cf0", 32'h10, OP_BR, 3'b110, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
      issue("bgeu_cf0", 32'h10, OP_BR, 3'b111, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      issue("blt_s1v0", 32'h10, OP_BR, 3'b100, 0, 0, 0, 1, 1'b0, 1'b1, 1'b1);
      issue("bge_s1v1", 32'h10, OP_BR, 3'b101, 0, 0, 1, 1, 1'b0, 1'b1, 1'b1);
      issue("bne_z1", 32'h10, OP_BR, 3'b001, 0, 1, 0, 0, 1'b0, 1'b0, 1'b0);
      issue("bad_func3", 32'h10, OP_BR, 3'b010, 0, 1, 0, 0, 1'b1, 1'b0, 1'b1);
      idle();
      if_pc = 32'h10;
      #1 chk("pred_0x10_after_train", 32'(pred_taken), 32'd0);
      chk("stat_branch_11", branch_cnt, 32'd11);
      chk("stat_mispredict_7", mispredict_cnt, 32'd7);

      // Same-index read and update in one cycle: no bypass.
      issue("beq_0x104", 32'h104, OP_BR, 3'b000, 0, 1, 0, 0, 1'b0, 1'b1, 1'b1);
      if_pc = 32'h104;
      #3 chk("same_cycle_pred_0x104_old", 32'(pred_taken), 32'd0);
      idle();
      chk("next_cycle_pred_0x104_new", 32'(pred_taken), 32'd1);
      if_pc = 32'h204;
      #1 chk("alias_pred_0x204", 32'(pred_taken), 32'd1);
      chk("stat_branch_12", branch_cnt, 32'd12);
      chk("stat_mispredict_8", mispredict_cnt, 32'd8);

      // Asynchronous reset between edges clears everything immediately.
      #1 rst = 1'b1;
      #1;
      chk("async_rst_pred_0x204", 32'(pred_taken), 32'd0);
      chk("async_rst_branch_cnt", branch_cnt, 32'd0);
      chk("async_rst_mispredict_cnt", mispredict_cnt, 32'd0);
      if_pc = 32'h100;
      #1 chk("async_rst_pred_0x100", 32'(pred_taken), 32'd0);

      // A resolve during reset must leave no trace.
      issue("beq_in_reset", 32'h104, OP_BR, 3'b000, 0, 1, 0, 0, 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      rst = 1'b0;
      if_pc = 32'h104;
      #1;
      chk("post_rst_pred_0x104", 32'(pred_taken), 32'd0);
      chk("post_rst_branch_cnt", branch_cnt, 32'd0);
      chk("post_rst_mispredict_cnt", mispredict_cnt, 32'd0);

      @(negedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
